// File: rtl/data_mem_dump_arbiter.sv
// Shares the single-port data_memory between the CPU (absolute priority) and a dump
// engine that streams words 0..DUMP_LEN-1 over valid/ready using only idle memory cycles.
module data_mem_dump_arbiter #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 11,
  parameter int DUMP_LEN      = 2**RAM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_write,
  input  logic [RAM_ADDR_BITS-1:0] cpu_addr,
  input  logic [RAM_WIDTH-1:0]     cpu_wdata,
  output logic [RAM_WIDTH-1:0]     cpu_rdata,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic                     dump_done,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [RAM_WIDTH-1:0]     dump_data,
  output logic                     mem_write,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_WIDTH-1:0]     mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Full-width compare so DUMP_LEN = 2**RAM_ADDR_BITS stops at all-ones without wrapping.
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(DUMP_LEN - 1);
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = RAM_ADDR_BITS'(1);

  logic [1:0]               state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     valid_q, valid_d;
  logic [RAM_WIDTH-1:0]     data_q, data_d;
  logic                     done_q, done_d;

  always_comb begin
    mem_wdata = cpu_wdata;
    if (cpu_req) begin
      mem_addr  = cpu_addr;
      mem_write = cpu_write;
    end else begin
      mem_addr  = addr_q;
      mem_write = 1'b0;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_done  = done_q;
  assign dump_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // The read of addr_q is issued only in a cycle the CPU leaves the memory idle.
        if (!cpu_req) begin
          data_d  = mem_rdata;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_data_mem_dump_arbiter.sv
// Bench for data_mem_dump_arbiter: three instances (DUMP_LEN 4, 1, 2048) each with its own
// falling-edge memory; a golden array tracks what the memory must hold after every CPU write.
module tb_data_mem_dump_arbiter;
  localparam int W = 16;
  localparam int AW = 11;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, cpu_req, cpu_write, rdy;
  logic [AW-1:0] cpu_addr;
  logic [W-1:0] cpu_wdata;
  logic st4, st1, stf;

  logic [W-1:0] rd4, rd1, rdf, dat4, dat1, datf, mwd4, mwd1, mwdf, mrd4, mrd1, mrdf;
  logic busy4, busy1, busyf, done4, done1, donef, vld4, vld1, vldf, mw4, mw1, mwf;
  logic [AW-1:0] ma4, ma1, maf;

  logic [W-1:0] mem4 [DEPTH];
  logic [W-1:0] mem1 [DEPTH];
  logic [W-1:0] memf [DEPTH];
  logic [W-1:0] gold [DEPTH];

  int tests = 0;
  int fails = 0;

  data_mem_dump_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW), .DUMP_LEN(4)) u4 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rd4), .dump_start(st4), .dump_busy(busy4),
    .dump_done(done4), .dump_valid(vld4), .dump_ready(rdy), .dump_data(dat4),
    .mem_write(mw4), .mem_addr(ma4), .mem_wdata(mwd4), .mem_rdata(mrd4));

  data_mem_dump_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW), .DUMP_LEN(1)) u1 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rd1), .dump_start(st1), .dump_busy(busy1),
    .dump_done(done1), .dump_valid(vld1), .dump_ready(rdy), .dump_data(dat1),
    .mem_write(mw1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mrd1));

  data_mem_dump_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW)) uf (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdf), .dump_start(stf), .dump_busy(busyf),
    .dump_done(donef), .dump_valid(vldf), .dump_ready(rdy), .dump_data(datf),
    .mem_write(mwf), .mem_addr(maf), .mem_wdata(mwdf), .mem_rdata(mrdf));

  // data_memory: write-first, address sampled at the falling edge
  always @(negedge clk) begin
    if (mw4) mem4[ma4] = mwd4;
    mrd4 = mem4[ma4];
    if (mw1) mem1[ma1] = mwd1;
    mrd1 = mem1[ma1];
    if (mwf) memf[maf] = mwdf;
    mrdf = memf[maf];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setmem(input int a, input logic [W-1:0] v);
    gold[a] = v;
    mem4[a] = v;
    mem1[a] = v;
    memf[a] = v;
  endtask

  task automatic preload_all();
    for (int i = 0; i < DEPTH; i++) setmem(i, W'($urandom));
  endtask

  task automatic preload4();
    setmem(0, 16'h0011);
    setmem(1, 16'h0022);
    setmem(2, 16'h0033);
    setmem(3, 16'h0044);
  endtask

  task automatic cpu_idle();
    cpu_req = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    cpu_req = 1'b1;
    cpu_write = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    gold[a] = d;
  endtask

  task automatic cpu_rand(input int unsigned pct, output logic is_rd, output logic [AW-1:0] a);
    a = AW'($urandom_range(DEPTH - 1));
    is_rd = 1'b0;
    if ($urandom_range(99) < pct) begin
      if ($urandom_range(1) == 1) begin
        cpu_wr(a, W'($urandom));
      end else begin
        cpu_req = 1'b1;
        cpu_write = 1'b0;
        cpu_addr = a;
        cpu_wdata = '0;
        is_rd = 1'b1;
      end
    end else begin
      cpu_idle();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++; if (vld4 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", vld4); end
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    tests++; if (done4 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done4); end
    tests++; if (dat4 !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", dat4); end
    tests++; if (ma4 !== 11'd0) begin fails++; $display("FAIL reset_dump_addr: got %0d expected 0", ma4); end
    tests++; if (mw4 !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b expected 0", mw4); end
    reset = 1'b0;
    tick();
    tests++; if (busy4 !== 1'b0 || busy1 !== 1'b0 || busyf !== 1'b0) begin
      fails++; $display("FAIL idle_busy: got %b%b%b expected 000", busy4, busy1, busyf); end
  endtask

  task automatic test_mux();
    logic [W-1:0] d;
    d = W'($urandom);
    cpu_wr(11'd5, d);
    #1;
    tests++; if (ma4 !== 11'd5 || mw4 !== 1'b1 || mwd4 !== d) begin
      fails++; $display("FAIL mux_write: got addr %0d we %b data %h expected 5 1 %h", ma4, mw4, mwd4, d); end
    tick();
    cpu_req = 1'b1;
    cpu_write = 1'b0;
    cpu_addr = 11'd5;
    #1;
    tests++; if (ma4 !== 11'd5 || mw4 !== 1'b0) begin
      fails++; $display("FAIL mux_read: got addr %0d we %b expected 5 0", ma4, mw4); end
    #4;
    tests++; if (rd4 !== d) begin fails++; $display("FAIL cpu_readback: got %h expected %h", rd4, d); end
    tick();
    cpu_idle();
    #1;
    tests++; if (ma4 !== 11'd0 || mw4 !== 1'b0) begin
      fails++; $display("FAIL mux_idle: got addr %0d we %b expected 0 0", ma4, mw4); end
    tick();
  endtask

  task automatic test_basic();
    int k, ndone, first, lastv, dcyc;
    logic pv;
    preload4();
    k = 0; ndone = 0; first = -1; lastv = -1; dcyc = -1; pv = 1'b0;
    rdy = 1'b1;
    cpu_idle();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (vld4 && !pv) begin
        tests++; if (k > 3 || dat4 !== gold[k]) begin
          fails++; $display("FAIL basic_word%0d: got %h expected %h", k, dat4, gold[k]); end
        if (k == 0) first = c;
        else begin
          tests++; if (c - lastv != 2) begin
            fails++; $display("FAIL basic_spacing%0d: got %0d cycles expected 2", k, c - lastv); end
        end
        lastv = c;
        k++;
      end
      if (done4) begin ndone++; dcyc = c; end
      pv = vld4;
      tick();
    end
    tests++; if (first != 2) begin fails++; $display("FAIL basic_first_latency: got %0d expected 2", first); end
    tests++; if (k != 4) begin fails++; $display("FAIL basic_count: got %0d expected 4", k); end
    tests++; if (ndone != 1 || dcyc != lastv + 1) begin
      fails++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", ndone, dcyc, lastv + 1); end
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b expected 0", busy4); end
  endtask

  task automatic test_cpu_stall();
    int k, ndone;
    logic pv;
    logic [W-1:0] got [4];
    preload4();
    k = 0; ndone = 0; pv = 1'b0;
    rdy = 1'b1;
    cpu_idle();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      if (vld4 && !pv) begin got[k] = dat4; k++; end
      pv = vld4;
      if (k < 2) tick();
    end
    tick();
    // FSM now waits in READ at address 2; the CPU owns the memory for 5 cycles
    for (int s = 0; s < 5; s++) begin
      if (s == 0) cpu_wr(11'd2, 16'hBEEF);
      else if (s == 1) cpu_wr(11'd0, W'($urandom));
      else if (s == 2) cpu_wr(11'd3, W'($urandom));
      else cpu_wr(AW'($urandom_range(DEPTH - 1, 4)), W'($urandom));
      tick();
      tests++; if (vld4 !== 1'b0) begin fails++; $display("FAIL stall_valid%0d: got %b expected 0", s, vld4); end
    end
    cpu_idle();
    pv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (vld4 && !pv) begin
        tests++; if (k > 3 || dat4 !== gold[k]) begin
          fails++; $display("FAIL stall_word%0d: got %h expected %h", k, dat4, gold[k]); end
        if (k < 4) got[k] = dat4;
        k++;
      end
      if (done4) ndone++;
      pv = vld4;
      tick();
    end
    tests++; if (k != 4 || ndone != 1) begin
      fails++; $display("FAIL stall_count: got %0d words %0d done expected 4 1", k, ndone); end
    tests++; if (got[2] !== 16'hBEEF) begin fails++; $display("FAIL stall_beef: got %h expected beef", got[2]); end
    tests++; if (got[0] !== 16'h0011) begin fails++; $display("FAIL stall_sent_unchanged: got %h expected 0011", got[0]); end
  endtask

  task automatic test_ready_hold();
    int k, ndone;
    logic pv, isr;
    logic [AW-1:0] a;
    logic [W-1:0] held;
    rdy = 1'b0;
    cpu_idle();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int c = 0; c < 10 && !vld4; c++) tick();
    held = dat4;
    tests++; if (vld4 !== 1'b1 || held !== gold[0]) begin
      fails++; $display("FAIL hold_first: got vld %b data %h expected 1 %h", vld4, held, gold[0]); end
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 2) begin cpu_idle(); isr = 1'b0; a = '0; end
      else cpu_rand(100, isr, a);
      #5;
      if (isr) begin
        tests++; if (rd4 !== gold[a]) begin
          fails++; $display("FAIL hold_cpu_read%0d: got %h expected %h at addr %0d", i, rd4, gold[a], a); end
      end else if (!cpu_req) begin
        tests++; if (ma4 !== 11'd0) begin
          fails++; $display("FAIL hold_dump_addr%0d: got %0d expected 0", i, ma4); end
      end
      tests++; if (vld4 !== 1'b1 || dat4 !== held) begin
        fails++; $display("FAIL hold_stable%0d: got vld %b data %h expected 1 %h", i, vld4, dat4, held); end
      tick();
    end
    rdy = 1'b1;
    cpu_idle();
    tick();
    k = 1; ndone = 0; pv = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (vld4 && !pv) begin
        tests++; if (k > 3 || dat4 !== gold[k]) begin
          fails++; $display("FAIL hold_word%0d: got %h expected %h", k, dat4, gold[k]); end
        k++;
      end
      if (done4) ndone++;
      pv = vld4;
      tick();
    end
    tests++; if (k != 4 || ndone != 1) begin
      fails++; $display("FAIL hold_count: got %0d words %0d done expected 4 1", k, ndone); end
  endtask

  task automatic test_restart_reset();
    int k, ndone;
    logic pv;
    preload4();
    rdy = 1'b1;
    cpu_idle();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int c = 0; c < 10 && !vld4; c++) tick();
    tests++; if (dat4 !== gold[0]) begin fails++; $display("FAIL restart_word0: got %h expected %h", dat4, gold[0]); end
    st4 = 1'b1;
    tick();
    tick();
    st4 = 1'b0;
    tests++; if (vld4 !== 1'b1 || dat4 !== gold[1]) begin
      fails++; $display("FAIL restart_ignored: got vld %b data %h expected 1 %h", vld4, dat4, gold[1]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (vld4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      fails++; $display("FAIL midreset: got vld %b busy %b done %b expected 0 0 0", vld4, busy4, done4); end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin
        fails++; $display("FAIL postreset%0d: got done %b busy %b expected 0 0", c, done4, busy4); end
    end
    k = 0; ndone = 0; pv = 1'b0;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (vld4 && !pv) begin
        tests++; if (k > 3 || dat4 !== gold[k]) begin
          fails++; $display("FAIL again_word%0d: got %h expected %h", k, dat4, gold[k]); end
        k++;
      end
      if (done4) ndone++;
      pv = vld4;
      tick();
    end
    tests++; if (k != 4 || ndone != 1) begin
      fails++; $display("FAIL again_count: got %0d words %0d done expected 4 1", k, ndone); end
  endtask

  task automatic test_len_one();
    int k, ndone;
    logic pv;
    k = 0; ndone = 0; pv = 1'b0;
    rdy = 1'b1;
    cpu_idle();
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (vld1 && !pv) begin
        tests++; if (dat1 !== gold[0]) begin fails++; $display("FAIL len1_word: got %h expected %h", dat1, gold[0]); end
        k++;
      end
      if (done1) ndone++;
      pv = vld1;
      tick();
    end
    tests++; if (k != 1 || ndone != 1 || busy1 !== 1'b0) begin
      fails++; $display("FAIL len1_count: got %0d words %0d done busy %b expected 1 1 0", k, ndone, busy1); end
  endtask

  task automatic test_len_full();
    int k, ndone;
    logic pv, isr;
    logic [AW-1:0] a;
    logic [W-1:0] pd;
    preload_all();
    k = 0; ndone = 0; pv = 1'b0; pd = '0;
    rdy = 1'b1;
    cpu_idle();
    stf = 1'b1;
    tick();
    stf = 1'b0;
    for (int c = 0; c < 13000 && ndone == 0; c++) begin
      if (vldf && !pv) begin
        tests++; if (k >= DEPTH) begin fails++; $display("FAIL full_extra_word: got word %0d expected none", k); end
        else if (datf !== gold[k]) begin fails++; $display("FAIL full_word%0d: got %h expected %h", k, datf, gold[k]); end
        k++;
      end else if (vldf) begin
        tests++; if (datf !== pd) begin fails++; $display("FAIL full_hold: got %h expected %h", datf, pd); end
      end
      if (donef) ndone++;
      pv = vldf;
      pd = datf;
      rdy = ($urandom_range(3) != 0);
      cpu_rand(20, isr, a);
      tick();
    end
    cpu_idle();
    tests++; if (k != DEPTH || ndone != 1) begin
      fails++; $display("FAIL full_count: got %0d words %0d done expected 2048 1", k, ndone); end
    for (int c = 0; c < 3; c++) begin
      tests++; if (vldf !== 1'b0 || busyf !== 1'b0 || donef !== 1'b0) begin
        fails++; $display("FAIL full_after%0d: got vld %b busy %b done %b expected 0 0 0", c, vldf, busyf, donef); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_idle();
    st4 = 1'b0;
    st1 = 1'b0;
    stf = 1'b0;
    rdy = 1'b0;
    preload_all();
    test_reset();
    test_mux();
    test_basic();
    test_cpu_stall();
    test_ready_hold();
    test_restart_reset();
    test_len_one();
    test_len_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
